inference_sequencer: RTL and testbench
======================================

INFERENCE_SEQUENCER -- requirements
Module: inference_sequencer

Interface
REQ-001 Parameter PACKETS_NUM, default 13: number of input beats per inference (one feature-slice packet per beat).
REQ-002 Parameter COUNT_WIDTH, default 32: width of the completed-inference counter.
REQ-003 Parameter TIMEOUT_CYCLES, default 256: adder watchdog limit; used only under SEQ_WATCHDOG_EN.
REQ-004 clk  in  1  single clock; all logic is rising-edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 s_valid  in  1  upstream beat valid.
REQ-007 s_last  in  1  upstream end-of-stream marker, qualified by the s_valid/s_ready handshake.
REQ-008 s_ready  out  1  block accepts a beat.
REQ-009 pkt_valid  out  PACKETS_NUM  one-hot load strobe to the clause-evaluation stages.
REQ-010 adder_start  out  1  one-cycle pulse that starts the class-sum adder.
REQ-011 adder_done  in  1  adder result ready; level or pulse.
REQ-012 argmax_en  out  1  one-cycle enable to the classifier.
REQ-013 m_valid  out  1  classification result valid toward the downstream stream.
REQ-014 m_last  out  1  end-of-stream marker for the current result.
REQ-015 m_ready  in  1  downstream accepts the result.
REQ-016 busy  out  1  high in every state except LOAD with pkt_idx==0.
REQ-017 inference_count  out  COUNT_WIDTH  number of completed result handshakes.
REQ-018 timeout_err  out  1  sticky adder-watchdog error flag.

Function
REQ-019 The FSM SHALL have four states, LOAD, ADD, ARGMAX and OUT, encoded in 2 bits.
REQ-020 In LOAD, s_ready SHALL be 1; in all other states it SHALL be 0.
REQ-021 Each handshake (s_valid&&s_ready at cycle T) SHALL set pkt_valid to one-hot bit pkt_idx at T+1 for exactly one cycle; otherwise pkt_valid SHALL be 0.
REQ-022 pkt_idx SHALL increment on each handshake; on the beat where pkt_idx==PACKETS_NUM-1 it SHALL wrap to 0 and the FSM SHALL enter ADD.
REQ-023 Any accepted beat with s_last=1 SHALL set last_pending, including a non-final beat.
REQ-024 On entry to ADD (cycle T+1), adder_start SHALL pulse for one cycle, coincident with the final pkt_valid bit.
REQ-025 In ADD, adder_done=1 at cycle D SHALL move the FSM to ARGMAX; argmax_en SHALL be 1 at D+1 only.
REQ-026 adder_done in any state other than ADD SHALL be ignored, including adder_done in the adder_start cycle.
REQ-027 ARGMAX SHALL last exactly one cycle, then move to OUT; m_valid SHALL first assert at D+2.
REQ-028 In OUT, m_valid=1 and m_last=last_pending SHALL be held stable until m_ready=1.
REQ-029 On the OUT handshake, the FSM SHALL return to LOAD, clear last_pending, and increment inference_count (modulo 2^COUNT_WIDTH).
REQ-030 m_ready=1 on the same cycle m_valid first rises SHALL complete the transfer in that cycle.
REQ-031 The minimum spacing between inferences SHALL be PACKETS_NUM + adder latency + 3 cycles; there is no overlap between inferences.

Reset
REQ-032 While rst=1, the following SHALL hold: state=LOAD, pkt_idx=0, last_pending=0.
REQ-033 While rst=1, all outputs SHALL be 0 except s_ready, which SHALL be 1; timeout_err SHALL be cleared.
REQ-034 Reset in any state, including mid-load and OUT with m_valid high, SHALL abandon the inference without incrementing inference_count; m_valid SHALL drop the cycle after rst is sampled.

Configuration
REQ-035 With SEQ_WATCHDOG_EN defined, a counter SHALL run in ADD; if TIMEOUT_CYCLES cycles pass without adder_done, timeout_err SHALL set (sticky until rst) and the FSM SHALL proceed to ARGMAX as if done.
REQ-036 Without SEQ_WATCHDOG_EN, ADD SHALL wait indefinitely, timeout_err SHALL be tied 0, and no watchdog counter SHALL be synthesised.

Verification
REQ-037 Scenario: 13 back-to-back beats, adder_done 5 cycles after adder_start, m_ready=1 -> pkt_valid walks bits 0..12, argmax_en one cycle, exactly one m_valid cycle, inference_count=1.
REQ-038 Scenario: m_ready held 0 for 10 cycles in OUT -> m_valid and m_last held stable, s_ready=0, no pkt_valid; after release the FSM returns to LOAD.
REQ-039 Scenario: s_last on beat 4 of 13 -> m_last=1 for that result; the next inference with no s_last gives m_last=0.
REQ-040 Scenario: rst pulsed after beat 7 -> pkt_idx=0; the next 13 beats give a normal result and inference_count=1.
REQ-041 Scenario: adder_done asserted during LOAD and in the adder_start cycle -> ignored; the FSM stays in LOAD/ADD.
REQ-042 Scenario (SEQ_WATCHDOG_EN, TIMEOUT_CYCLES=16): adder_done never asserts -> timeout_err=1 in cycle 17 of ADD, the result is still emitted, and the flag stays set until rst.

Source files
------------

// File: rtl/inference_sequencer_if.sv
// inference_sequencer_if: stream, stage-strobe and status signals of the inference sequencer
interface inference_sequencer_if #(
  parameter int PACKETS_NUM = 13,
  parameter int COUNT_WIDTH = 32
);
  logic s_valid;
  logic s_last;
  logic s_ready;
  logic [PACKETS_NUM-1:0] pkt_valid;
  logic adder_start;
  logic adder_done;
  logic argmax_en;
  logic m_valid;
  logic m_last;
  logic m_ready;
  logic busy;
  logic [COUNT_WIDTH-1:0] inference_count;
  logic timeout_err;
  modport master (
    output s_valid, s_last, adder_done, m_ready,
    input  s_ready, pkt_valid, adder_start, argmax_en, m_valid, m_last, busy, inference_count, timeout_err
  );
  modport slave (
    input  s_valid, s_last, adder_done, m_ready,
    output s_ready, pkt_valid, adder_start, argmax_en, m_valid, m_last, busy, inference_count, timeout_err
  );
endinterface

// File: rtl/inference_sequencer.sv
// inference_sequencer: load/add/argmax/out control FSM; SEQ_WATCHDOG_EN adds an adder timeout
module inference_sequencer #(
  parameter int PACKETS_NUM    = 13,
  parameter int COUNT_WIDTH    = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic clk,
  input logic rst,
  inference_sequencer_if.slave bus
);
  localparam int IW = PACKETS_NUM > 1 ? $clog2(PACKETS_NUM) : 1;
  typedef enum logic [1:0] {LOAD, ADD, ARGMAX, OUT} state_t;
  state_t state, state_n;
  logic [IW-1:0] pkt_idx;
  logic [PACKETS_NUM-1:0] pkt_valid_q;
  logic [COUNT_WIDTH-1:0] count_q;
  logic last_pending, adder_start_q, hs, final_beat, done_ok, out_hs, wd_expire;
  if (PACKETS_NUM < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("inference_sequencer: PACKETS_NUM must be >= 2 and TIMEOUT_CYCLES >= 1");
  end
  assign hs = bus.s_valid && state == LOAD;
  assign final_beat = pkt_idx == IW'(PACKETS_NUM - 1);
  assign done_ok = state == ADD && bus.adder_done && !adder_start_q;
  assign out_hs = state == OUT && bus.m_ready;
`ifdef SEQ_WATCHDOG_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wd_cnt;
  logic timeout_q;
  assign wd_expire = state == ADD && !done_ok && wd_cnt == WW'(TIMEOUT_CYCLES - 1);
  // watchdog counts ADD cycles and latches a sticky timeout when the adder never answers
  always_ff @(posedge clk) begin
    wd_cnt <= rst || state != ADD ? '0 : wd_cnt + 1'b1;
    timeout_q <= rst ? 1'b0 : timeout_q || wd_expire;
  end
  assign bus.timeout_err = timeout_q;
`else
  assign wd_expire = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif
  // state register
  always_ff @(posedge clk) begin
    state <= rst ? LOAD : state_n;
  end
  // next state: adder_done only counts in ADD after the start cycle
  always_comb begin
    state_n = state;
    case (state)
      LOAD:    state_n = hs && final_beat ? ADD : LOAD;
      ADD:     state_n = done_ok || wd_expire ? ARGMAX : ADD;
      ARGMAX:  state_n = OUT;
      OUT:     state_n = bus.m_ready ? LOAD : OUT;
      default: state_n = LOAD;
    endcase
  end
  // beat index, stage strobes, end-of-stream tracking and result counter
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_idx <= '0;
      pkt_valid_q <= '0;
      adder_start_q <= 1'b0;
      last_pending <= 1'b0;
      count_q <= '0;
    end else begin
      pkt_valid_q <= hs ? PACKETS_NUM'(1) << pkt_idx : '0;
      adder_start_q <= hs && final_beat;
      if (hs) pkt_idx <= final_beat ? '0 : pkt_idx + 1'b1;
      last_pending <= (hs && bus.s_last) || (last_pending && !out_hs);
      if (out_hs) count_q <= count_q + 1'b1;
    end
  end
  assign bus.s_ready = state == LOAD;
  assign bus.pkt_valid = pkt_valid_q;
  assign bus.adder_start = adder_start_q;
  assign bus.argmax_en = state == ARGMAX;
  assign bus.m_valid = state == OUT;
  assign bus.m_last = state == OUT && last_pending;
  assign bus.busy = !(state == LOAD && pkt_idx == '0);
  assign bus.inference_count = count_q;
endmodule

// File: tb/tb_inference_sequencer.sv
// tb_inference_sequencer: table-driven inference scenarios plus reset and watchdog sequences
module tb_inference_sequencer;
  localparam int P = 13;
  localparam int CW = 32;
  logic clk = 0;
  logic rst = 1;
  int total = 0;
  int bad = 0;
  int cnt = 0;
  inference_sequencer_if #(.PACKETS_NUM(P), .COUNT_WIDTH(CW)) bus ();
  inference_sequencer #(.PACKETS_NUM(P), .COUNT_WIDTH(CW), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  typedef struct {
    int lb;
    int lat;
    int hold;
    bit early;
    bit exp_last;
  } vec_t;
  vec_t vecs[6];
  function automatic logic [P-1:0] onehot(input int i);
    logic [P-1:0] r;
    r = '0;
    r[i] = 1'b1;
    return r;
  endfunction
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", n, a, e);
    end
  endtask
  task automatic load(input int lb, input bit early);
    for (int i = 0; i < P; i++) begin
      @(negedge clk);
      chk("s_ready_load", bus.s_ready, 1);
      chk("busy_load", bus.busy, i > 0);
      chk("pkt_walk", bus.pkt_valid, i > 0 ? onehot(i - 1) : '0);
      bus.s_valid = 1;
      bus.s_last = i == lb;
      bus.adder_done = early;
    end
    @(negedge clk);
    bus.s_last = 0;
    chk("pkt_final", bus.pkt_valid, onehot(P - 1));
    chk("adder_start", bus.adder_start, 1);
    chk("s_ready_add", bus.s_ready, 0);
    chk("busy_add", bus.busy, 1);
  endtask
  task automatic run(input vec_t v);
    load(v.lb, v.early);
    repeat (v.lat) begin
      @(negedge clk);
      bus.adder_done = 0;
      chk("start_pulse", bus.adder_start, 0);
      chk("argmax_early", bus.argmax_en, 0);
      chk("mvalid_early", bus.m_valid, 0);
      chk("pkt_idle_add", bus.pkt_valid, 0);
    end
    bus.adder_done = 1;
    @(negedge clk);
    bus.adder_done = 0;
    chk("argmax_en", bus.argmax_en, 1);
    chk("mvalid_argmax", bus.m_valid, 0);
    @(negedge clk);
    chk("argmax_once", bus.argmax_en, 0);
    chk("m_valid", bus.m_valid, 1);
    chk("m_last", bus.m_last, v.exp_last);
    repeat (v.hold) begin
      @(negedge clk);
      chk("hold_valid", bus.m_valid, 1);
      chk("hold_last", bus.m_last, v.exp_last);
      chk("hold_sready", bus.s_ready, 0);
      chk("hold_pkt", bus.pkt_valid, 0);
    end
    bus.s_valid = 0;
    bus.m_ready = 1;
    @(negedge clk);
    bus.m_ready = 0;
    cnt++;
    chk("mvalid_drop", bus.m_valid, 0);
    chk("back_load", bus.s_ready, 1);
    chk("busy_idle", bus.busy, 0);
    chk("count", bus.inference_count, cnt);
    chk("timeout_clear", bus.timeout_err, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog_time got=running want=finished");
    $fatal(1, "time limit");
  end
  initial begin
    vecs[0] = '{-1, 5, 0, 1'b0, 1'b0};
    vecs[1] = '{-1, 3, 10, 1'b0, 1'b0};
    vecs[2] = '{4, 2, 1, 1'b0, 1'b1};
    vecs[3] = '{-1, 5, 0, 1'b0, 1'b0};
    vecs[4] = '{12, 1, 2, 1'b1, 1'b1};
    vecs[5] = '{0, 7, 0, 1'b0, 1'b1};
    bus.s_valid = 0;
    bus.s_last = 0;
    bus.adder_done = 0;
    bus.m_ready = 0;
    repeat (3) @(negedge clk);
    chk("rst_sready", bus.s_ready, 1);
    chk("rst_pkt", bus.pkt_valid, 0);
    chk("rst_start", bus.adder_start, 0);
    chk("rst_argmax", bus.argmax_en, 0);
    chk("rst_mvalid", bus.m_valid, 0);
    chk("rst_mlast", bus.m_last, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_count", bus.inference_count, 0);
    chk("rst_timeout", bus.timeout_err, 0);
    rst = 0;
    for (int k = 0; k < 6; k++) run(vecs[k]);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      bus.s_valid = 1;
      bus.s_last = i == 2;
    end
    @(negedge clk);
    bus.s_valid = 0;
    bus.s_last = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    cnt = 0;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_count", bus.inference_count, 0);
    chk("midrst_sready", bus.s_ready, 1);
    chk("midrst_pkt", bus.pkt_valid, 0);
    run('{-1, 5, 0, 1'b0, 1'b0});
    load(-1, 1'b0);
    bus.s_valid = 0;
    @(negedge clk);
    bus.adder_done = 1;
    @(negedge clk);
    bus.adder_done = 0;
    @(negedge clk);
    chk("outrst_mvalid_pre", bus.m_valid, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    cnt = 0;
    chk("outrst_mvalid", bus.m_valid, 0);
    chk("outrst_count", bus.inference_count, 0);
    chk("outrst_sready", bus.s_ready, 1);
    run('{3, 2, 0, 1'b0, 1'b1});
`ifdef SEQ_WATCHDOG_EN
    load(-1, 1'b0);
    bus.s_valid = 0;
    repeat (15) @(negedge clk);
    chk("wd_before", bus.timeout_err, 0);
    chk("wd_argmax_before", bus.argmax_en, 0);
    @(negedge clk);
    chk("wd_set", bus.timeout_err, 1);
    chk("wd_argmax", bus.argmax_en, 1);
    @(negedge clk);
    chk("wd_mvalid", bus.m_valid, 1);
    bus.m_ready = 1;
    @(negedge clk);
    bus.m_ready = 0;
    cnt++;
    chk("wd_count", bus.inference_count, cnt);
    chk("wd_sticky", bus.timeout_err, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("wd_rst", bus.timeout_err, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
